rob_commit: RTL and testbench

Reorder buffer that accepts renamed instructions from the rename stage, tracks completion from the CDB, and retires them in program order. It sits between rename (allocation side) and the retirement RAT / free list (commit side). Allocation writes an entry at the tail, and the tail index is exported as the ROB ID. Commit reads the head entry and presents its architectural/physical destination so the previous mapping can be retired and the physical register recycled.

---
 rtl/rob_commit.sv | 110 +++++++++++
 tb/tb_rob_commit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement reorder buffer.
// Entries are allocated at the tail by rename, marked ready by the CDB and
// retired from the head one per cycle, in program order.
// Optional feature macro: ROB_FLUSH_EN adds a 'flush' input that empties the
// buffer at the next edge, with priority over every other event.
module rob_commit #(
  parameter int ROB_DEPTH     = 16,
  parameter int ROB_IDX_SIZE  = 4,
  parameter int PHYS_REG_ADDR = 6
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_valid,
  input  logic [PHYS_REG_ADDR-1:0] alloc_phys_addr,
  input  logic [4:0]               alloc_rd_addr,
  output logic [ROB_IDX_SIZE-1:0]  alloc_rob_id,
  output logic                     rob_full,
  output logic                     rob_empty,
  input  logic                     cdb_valid,
  input  logic [ROB_IDX_SIZE-1:0]  cdb_rob_id,
  output logic                     commit_valid,
  output logic [ROB_IDX_SIZE-1:0]  commit_rob_id,
  output logic [4:0]               commit_rd_addr,
  output logic [PHYS_REG_ADDR-1:0] commit_phys_addr
);

  localparam int PTR_W = ROB_IDX_SIZE + 1;

  logic [PTR_W-1:0]         head_ptr;
  logic [PTR_W-1:0]         tail_ptr;
  logic [ROB_IDX_SIZE-1:0]  head_idx;
  logic [ROB_IDX_SIZE-1:0]  tail_idx;
  logic [ROB_DEPTH-1:0]     valid_q;
  logic [ROB_DEPTH-1:0]     ready_q;
  logic [PHYS_REG_ADDR-1:0] phys_mem [ROB_DEPTH];
  logic [4:0]               rd_mem   [ROB_DEPTH];
  logic                     flush_now;
  logic                     alloc_fire;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign head_idx     = head_ptr[ROB_IDX_SIZE-1:0];
  assign tail_idx     = tail_ptr[ROB_IDX_SIZE-1:0];
  assign alloc_rob_id = tail_idx;

  // Occupancy flags from the registered pointers; the wrap bit separates full from empty
  always_comb begin
    rob_empty = (head_ptr == tail_ptr);
    rob_full  = (head_idx == tail_idx) &&
                (head_ptr[ROB_IDX_SIZE] != tail_ptr[ROB_IDX_SIZE]);
  end

  // Full is judged on pre-commit state, so a retiring head never frees a slot in the same cycle
  always_comb begin
    alloc_fire   = alloc_valid && !rob_full && !flush_now;
    commit_valid = valid_q[head_idx] && ready_q[head_idx] && !rob_empty && !flush_now;
  end

  // Retirement outputs show the head entry only while it retires, otherwise zero
  always_comb begin
    commit_rob_id    = '0;
    commit_rd_addr   = '0;
    commit_phys_addr = '0;
    if (commit_valid) begin
      commit_rob_id    = head_idx;
      commit_rd_addr   = rd_mem[head_idx];
      commit_phys_addr = phys_mem[head_idx];
    end
  end

  // Pointers and per-entry status; commit is applied last so it clears a just-readied head
  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      valid_q  <= '0;
      ready_q  <= '0;
    end else begin
      if (cdb_valid && valid_q[cdb_rob_id]) begin
        ready_q[cdb_rob_id] <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        ready_q[tail_idx] <= 1'b0;
        tail_ptr          <= tail_ptr + PTR_W'(1);
      end
      if (commit_valid) begin
        valid_q[head_idx] <= 1'b0;
        ready_q[head_idx] <= 1'b0;
        head_ptr          <= head_ptr + PTR_W'(1);
      end
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      phys_mem[tail_idx] <= alloc_phys_addr;
      rd_mem[tail_idx]   <= alloc_rd_addr;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: scoreboard bench for rob_commit.
// Accepted allocations are queued in program order; every retirement the DUT
// reports is popped and compared, and idle cycles must show zeroed outputs.
module tb_rob_commit;

  logic       clk = 1'b0;
  logic       rst;
`ifdef ROB_FLUSH_EN
  logic       flush;
`endif
  logic       alloc_valid;
  logic [5:0] alloc_phys_addr;
  logic [4:0] alloc_rd_addr;
  logic [3:0] alloc_rob_id;
  logic       rob_full;
  logic       rob_empty;
  logic       cdb_valid;
  logic [3:0] cdb_rob_id;
  logic       commit_valid;
  logic [3:0] commit_rob_id;
  logic [4:0] commit_rd_addr;
  logic [5:0] commit_phys_addr;

  typedef struct packed {
    logic [3:0] id;
    logic [4:0] rd;
    logic [5:0] phys;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         model_count = 0;
  logic [3:0] model_tail = '0;

  always #5 clk = ~clk;

  rob_commit #(
    .ROB_DEPTH(16),
    .ROB_IDX_SIZE(4),
    .PHYS_REG_ADDR(6)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid),
    .alloc_phys_addr(alloc_phys_addr),
    .alloc_rd_addr(alloc_rd_addr),
    .alloc_rob_id(alloc_rob_id),
    .rob_full(rob_full),
    .rob_empty(rob_empty),
    .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id),
    .commit_valid(commit_valid),
    .commit_rob_id(commit_rob_id),
    .commit_rd_addr(commit_rd_addr),
    .commit_phys_addr(commit_phys_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drop all one-shot inputs
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
`ifdef ROB_FLUSH_EN
    flush       = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    model_count = 0;
    model_tail  = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [5:0] phys);
    exp_t e;
    alloc_valid     = 1'b1;
    alloc_rd_addr   = rd;
    alloc_phys_addr = phys;
    if (model_count < 16) begin
      e.id   = model_tail;
      e.rd   = rd;
      e.phys = phys;
      sb.push_back(e);
      model_tail  = model_tail + 4'd1;
      model_count = model_count + 1;
    end
  endtask

  task automatic cdb(input logic [3:0] id);
    cdb_valid  = 1'b1;
    cdb_rob_id = id;
  endtask

  // Scoreboard side: every retirement must match the oldest accepted allocation
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_valid) begin
        if (sb.size() == 0) begin
          check("commit_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          model_count = model_count - 1;
          check("commit_id", 32'(commit_rob_id), 32'(e.id));
          check("commit_rd", 32'(commit_rd_addr), 32'(e.rd));
          check("commit_phys", 32'(commit_phys_addr), 32'(e.phys));
        end
      end else begin
        check("commit_idle_zero", 32'({commit_rob_id, commit_rd_addr, commit_phys_addr}), 32'd0);
      end
    end
  end

  initial begin
    logic [3:0] id;
    rst             = 1'b1;
    alloc_valid     = 1'b0;
    alloc_phys_addr = '0;
    alloc_rd_addr   = '0;
    cdb_valid       = 1'b0;
    cdb_rob_id      = '0;
`ifdef ROB_FLUSH_EN
    flush           = 1'b0;
`endif
    do_reset();

    // reset / idle state
    tick();
    check("rst_empty", 32'(rob_empty), 32'd1);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_alloc_id", 32'(alloc_rob_id), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);

    // out-of-order completion, in-order retirement
    alloc(5'd5, 6'd33);
    tick();
    check("alloc_id_1", 32'(alloc_rob_id), 32'd1);
    check("not_empty", 32'(rob_empty), 32'd0);
    alloc(5'd7, 6'd40);
    tick();
    check("alloc_id_2", 32'(alloc_rob_id), 32'd2);
    cdb(4'd1);
    tick();
    check("ooo_no_commit", 32'(commit_valid), 32'd0);
    cdb(4'd0);
    tick();
    check("ooo_commit0_valid", 32'(commit_valid), 32'd1);
    check("ooo_commit0_rd", 32'(commit_rd_addr), 32'd5);
    tick();
    check("ooo_commit1_valid", 32'(commit_valid), 32'd1);
    check("ooo_commit1_phys", 32'(commit_phys_addr), 32'd40);
    tick();
    check("ooo_drained", 32'(rob_empty), 32'd1);

    // fill to full; entry 0 carries rd 0 and must still retire
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i), 6'(i + 16));
      tick();
    end
    check("full_flag", 32'(rob_full), 32'd1);
    check("full_alloc_id", 32'(alloc_rob_id), 32'd0);
    alloc(5'd30, 6'd63);
    tick();
    check("overflow_id", 32'(alloc_rob_id), 32'd0);
    check("overflow_full", 32'(rob_full), 32'd1);
    cdb(4'd0);
    tick();
    check("rd0_commit_valid", 32'(commit_valid), 32'd1);
    check("rd0_commit_rd", 32'(commit_rd_addr), 32'd0);
    tick();
    check("after_commit_not_full", 32'(rob_full), 32'd0);
    alloc(5'd9, 6'd50);
    tick();
    check("wrap_alloc_id", 32'(alloc_rob_id), 32'd1);
    check("wrap_full", 32'(rob_full), 32'd1);

    // full + head ready + alloc: commit happens, alloc rejected
    cdb(4'd1);
    tick();
    check("fc_commit_valid", 32'(commit_valid), 32'd1);
    check("fc_full_pre", 32'(rob_full), 32'd1);
    alloc(5'd3, 6'd3);
    tick();
    check("fc_tail_unchanged", 32'(alloc_rob_id), 32'd1);
    check("fc_not_full", 32'(rob_full), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      id = 4'(i);
      cdb(id);
      tick();
    end
    tick();
    tick();
    check("drain_empty", 32'(rob_empty), 32'd1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // CDB to an unallocated entry must not leave it ready
    do_reset();
    cdb(4'd9);
    tick();
    for (int i = 0; i < 10; i++) begin
      alloc(5'(i + 1), 6'(i + 1));
      tick();
    end
    check("stale_cdb_id", 32'(alloc_rob_id), 32'd10);
    for (int i = 0; i < 9; i++) begin
      id = 4'(i);
      cdb(id);
      tick();
    end
    tick();
    tick();
    check("stale_no_commit", 32'(commit_valid), 32'd0);
    check("stale_not_empty", 32'(rob_empty), 32'd0);
    cdb(4'd9);
    tick();
    check("late_commit_valid", 32'(commit_valid), 32'd1);
    check("late_commit_id", 32'(commit_rob_id), 32'd9);
    tick();
    check("late_empty", 32'(rob_empty), 32'd1);

`ifdef ROB_FLUSH_EN
    // flush wins over a ready head
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 4), 6'(i + 8));
      tick();
    end
    cdb(4'd0);
    tick();
    flush = 1'b1;
    sb.delete();
    model_count = 0;
    model_tail  = '0;
    #1;
    check("flush_commit_blocked", 32'(commit_valid), 32'd0);
    tick();
    check("flush_empty", 32'(rob_empty), 32'd1);
    check("flush_alloc_id", 32'(alloc_rob_id), 32'd0);
    check("flush_no_commit", 32'(commit_valid), 32'd0);
`endif

    tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
